flash_store: RTL and testbench

On-chip flash model and entry manager for the password keeper. It holds up to 16 records of 256 bits, each being {account[127:0], encrypted password[127:0]}. It serves registered reads and writes to the core, and reports the extent of valid entries as max_address. On reset it rebuilds its entry count by scanning the array, and it provides a sequenced whole-array erase.

---
 rtl/flash_store_if.sv | 33 +++
 rtl/flash_store.sv | 138 +++++++++++++
 tb/tb_flash_store.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/flash_store_if.sv
`default_nettype none
// ============================================================================
// Module   : flash_store_if
// Brief    : Core-to-flash bus: address, write record/strobe, erase, status.
// Revision : 1.0
// ============================================================================
interface flash_store_if #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
);
    logic [ADDR_W-1:0] add_flash;
    logic [WIDTH-1:0]  write_data_flash;
    logic              flash_write;
    logic              erase;
    logic [WIDTH-1:0]  data_flash;
    logic [ADDR_W-1:0] max_address;
    logic              empty;
    logic              full;
    logic              busy;
    logic              err;

    modport master (
        output add_flash, write_data_flash, flash_write, erase,
        input  data_flash, max_address, empty, full, busy, err
    );

    modport slave (
        input  add_flash, write_data_flash, flash_write, erase,
        output data_flash, max_address, empty, full, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/flash_store.sv
`default_nettype none
// ============================================================================
// Module   : flash_store
// Brief    : Record flash model with entry count rebuild scan and bulk erase.
// Revision : 1.0
// ============================================================================
module flash_store #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 256
) (
    input  wire logic     clk,
    input  wire logic     rst,
    flash_store_if.slave  bus
);
    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = $clog2(DEPTH + 1);
    localparam logic [c_addr_w-1:0] c_last_idx  = c_addr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0]  c_full_cnt  = c_cnt_w'(DEPTH);

    typedef enum logic [1:0] {
        ST_SCAN  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ERASE = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_addr_w-1:0] r_scan_idx, w_scan_idx_nxt;
    logic [c_addr_w-1:0] r_erase_idx, w_erase_idx_nxt;
    logic [c_cnt_w-1:0]  r_count, w_count_nxt;
    logic                r_err, w_err_nxt;
    logic [WIDTH-1:0]    r_data;

    logic                w_wr_en;
    logic [c_addr_w-1:0] w_wr_addr;
    logic [WIDTH-1:0]    w_wr_data;
    logic                w_full;
    logic [c_cnt_w-1:0]  w_add_ext;

    // Array content survives reset; the configuration image is all-zero.
    logic [WIDTH-1:0]    r_mem [DEPTH];

    assign w_full    = (r_count == c_full_cnt);
    assign w_add_ext = c_cnt_w'(bus.add_flash);

    always_comb begin
        w_state_nxt     = r_state;
        w_scan_idx_nxt  = r_scan_idx;
        w_erase_idx_nxt = r_erase_idx;
        w_count_nxt     = r_count;
        w_err_nxt       = 1'b0;
        w_wr_en         = 1'b0;
        w_wr_addr       = bus.add_flash;
        w_wr_data       = bus.write_data_flash;
        case (r_state)
            ST_SCAN: begin
                w_err_nxt = bus.flash_write;
                // First record with a zero account field marks the end of the valid run.
                if (r_mem[r_scan_idx][WIDTH-1:WIDTH/2] == '0) begin
                    w_count_nxt = c_cnt_w'(r_scan_idx);
                    w_state_nxt = ST_IDLE;
                end else if (r_scan_idx == c_last_idx) begin
                    w_count_nxt = c_full_cnt;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_scan_idx_nxt = r_scan_idx + 1'b1;
                end
            end
            ST_IDLE: begin
                if (bus.flash_write) begin
                    if (w_add_ext <= r_count) begin
                        w_wr_en = 1'b1;
                        if ((w_add_ext == r_count) && !w_full) begin
                            w_count_nxt = r_count + 1'b1;
                        end
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                if (bus.erase) begin
                    w_state_nxt     = ST_ERASE;
                    w_erase_idx_nxt = '0;
                end
            end
            ST_ERASE: begin
                w_err_nxt = bus.flash_write;
                w_wr_en   = 1'b1;
                w_wr_addr = r_erase_idx;
                w_wr_data = '0;
                if (r_erase_idx == c_last_idx) begin
                    w_count_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_erase_idx_nxt = r_erase_idx + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_SCAN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_SCAN;
            r_scan_idx  <= '0;
            r_erase_idx <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_data      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_scan_idx  <= w_scan_idx_nxt;
            r_erase_idx <= w_erase_idx_nxt;
            r_count     <= w_count_nxt;
            r_err       <= w_err_nxt;
            // Write-first: a same-cycle write to the read address is returned directly.
            if (w_wr_en && (w_wr_addr == bus.add_flash)) begin
                r_data <= w_wr_data;
            end else begin
                r_data <= r_mem[bus.add_flash];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    assign bus.data_flash  = r_data;
    assign bus.err         = r_err;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.empty       = (r_count == '0);
    assign bus.full        = w_full;
    assign bus.max_address = (r_count == '0) ? '0 : c_addr_w'(r_count - 1'b1);
endmodule
`default_nettype wire

// File: tb/tb_flash_store.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_store
// Brief    : Directed plus randomized bench for flash_store against a record model.
// Revision : 1.0
// ============================================================================
module tb_flash_store;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    flash_store_if #(.DEPTH(16), .WIDTH(256)) fif ();

    flash_store #(.DEPTH(16), .WIDTH(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (fif)
    );

    // Reference model: records, count and remaining busy cycles.
    logic [255:0] m_mem [16];
    int           m_count       = 0;
    int           m_busy_left   = 0;
    int           m_scan_result = 0;
    bit           m_erasing     = 1'b0;
    bit           m_err         = 1'b0;
    bit           m_valid       = 1'b0;
    logic [255:0] m_data        = '0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int a;
        a = int'(fif.add_flash);
        if (!rst) begin
            m_scan_result = 16;
            for (int i = 15; i >= 0; i--) begin
                if (m_mem[i][255:128] == '0) m_scan_result = i;
            end
            m_busy_left = (m_scan_result == 16) ? 16 : m_scan_result + 1;
            m_erasing   = 1'b0;
            m_count     = 0;
            m_err       = 1'b0;
            m_data      = '0;
            m_valid     = 1'b1;
        end else begin
            m_err = 1'b0;
            if (m_busy_left > 0) begin
                if (fif.flash_write) m_err = 1'b1;
                if (m_erasing) m_mem[16 - m_busy_left] = '0;
                m_busy_left--;
                if (m_busy_left == 0) m_count = m_erasing ? 0 : m_scan_result;
            end else begin
                if (fif.flash_write) begin
                    if (a <= m_count) begin
                        m_mem[a] = fif.write_data_flash;
                        if (a == m_count && m_count < 16) m_count++;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                if (fif.erase) begin
                    m_busy_left = 16;
                    m_erasing   = 1'b1;
                end
            end
            m_data = m_mem[a];
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("data_flash", fif.data_flash, m_data);
                chk("busy", 256'(fif.busy), 256'(m_busy_left > 0));
                chk("err", 256'(fif.err), 256'(m_err));
                chk("empty", 256'(fif.empty), 256'(m_count == 0));
                chk("full", 256'(fif.full), 256'(m_count == 16));
                chk("max_address", 256'(fif.max_address),
                    256'((m_count == 0) ? 0 : (m_count - 1) % 16));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic wr(input int a, input logic [255:0] d);
        fif.add_flash        = 4'(a);
        fif.write_data_flash = d;
        fif.flash_write      = 1'b1;
        @(negedge clk);
        fif.flash_write      = 1'b0;
    endtask

    task automatic rd(input int a, input logic [255:0] exp, input string nm);
        fif.add_flash = 4'(a);
        @(negedge clk);
        chk(nm, fif.data_flash, exp);
    endtask

    // Counts edges from the current negedge until busy is observed low.
    task automatic busy_len(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (!fif.busy) break;
        end
    endtask

    initial begin
        int n;
        int err_seen;
        fif.add_flash        = '0;
        fif.write_data_flash = '0;
        fif.flash_write      = 1'b0;
        fif.erase            = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 256'(fif.busy), 256'd1);
        chk("reset_data", fif.data_flash, 256'd0);
        @(negedge clk);
        rst = 1'b1;
        busy_len(n);
        chk("scan_len_empty", 256'(n), 256'd1);
        chk("empty_after_scan", 256'(fif.empty), 256'd1);
        chk("max_after_scan", 256'(fif.max_address), 256'd0);

        for (int i = 0; i < 3; i++) wr(i, {128'(i + 1), 128'(32'hA000 + i)});
        chk("max_after_3", 256'(fif.max_address), 256'd2);
        chk("empty_after_3", 256'(fif.empty), 256'd0);
        rd(1, {128'h2, 128'hA001}, "read_addr1");

        wr(5, rnd256());
        chk("reject_err", 256'(fif.err), 256'd1);
        chk("reject_count", 256'(fif.max_address), 256'd2);
        @(negedge clk);
        chk("reject_err_drop", 256'(fif.err), 256'd0);
        rd(5, 256'd0, "reject_mem5");
        wr(1, {128'h22, 128'hB1});
        chk("overwrite_count", 256'(fif.max_address), 256'd2);
        rd(1, {128'h22, 128'hB1}, "overwrite_read");

        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        busy_len(n);
        chk("scan_len_3", 256'(n), 256'd4);
        chk("max_after_rescan", 256'(fif.max_address), 256'd2);
        rd(0, {128'h1, 128'hA000}, "rescan_read0");
        rd(2, {128'h3, 128'hA002}, "rescan_read2");

        for (int i = 3; i < 16; i++) wr(i, {128'(i + 1), 128'(32'hC000 + i)});
        chk("full_16", 256'(fif.full), 256'd1);
        chk("max_16", 256'(fif.max_address), 256'd15);
        wr(15, {128'hFF, 128'hD15});
        chk("ow15_err", 256'(fif.err), 256'd0);
        chk("ow15_full", 256'(fif.full), 256'd1);

        fif.erase = 1'b1;
        @(negedge clk);
        fif.erase = 1'b0;
        n = 0;
        err_seen = 0;
        for (int i = 0; i < 40; i++) begin
            fif.flash_write      = (n == 4);
            fif.add_flash        = 4'd3;
            fif.write_data_flash = {128'h77, 128'h77};
            @(negedge clk);
            n++;
            if (fif.err) err_seen++;
            if (!fif.busy) break;
        end
        fif.flash_write = 1'b0;
        chk("erase_len", 256'(n), 256'd16);
        chk("erase_err", 256'(err_seen), 256'd1);
        chk("erase_empty", 256'(fif.empty), 256'd1);
        for (int i = 0; i < 16; i++) rd(i, 256'd0, "erase_read");

        // Randomized traffic with occasional erases and resets.
        for (int c = 0; c < 1500; c++) begin
            logic [255:0] d;
            rst             = ($urandom_range(0, 99) != 0);
            fif.flash_write = $urandom_range(0, 1);
            fif.erase       = ($urandom_range(0, 59) == 0);
            if (m_count < 16 && $urandom_range(0, 1) == 1) fif.add_flash = 4'(m_count);
            else fif.add_flash = 4'($urandom_range(0, 15));
            d = rnd256();
            if ($urandom_range(0, 9) == 0) d[255:128] = '0;
            fif.write_data_flash = d;
            @(negedge clk);
        end
        rst             = 1'b1;
        fif.flash_write = 1'b0;
        fif.erase       = 1'b0;
        repeat (40) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
